seven_segment_decoder: RTL

- Receive-side counterpart of the two-digit multiplexed seven-segment driver.
- Samples the `segments`/`digit` bus, filters for stability and maps each 7-bit pattern back to a 4-bit code.
- Pairs a unit digit with the ten digit that follows it, then presents the pair with a one-cycle valid strobe.
- Used as a self-checking display monitor in the frequency-counter top level, and as a bench-side reader.

---
 rtl/seven_segment_pkg.sv | 24 ++
 rtl/seven_segment_decoder_seg_pattern_decode.sv | 30 +++
 rtl/seven_segment_decoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment driver/decoder pair.
// Segment patterns (bit 6 = g .. bit 0 = a), blank code, FSM states.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111100;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    WAIT_UNIT = 1'b0,
    WAIT_TEN  = 1'b1
  } state_e;

endpackage

// File: rtl/seven_segment_decoder_seg_pattern_decode.sv
// Maps a 7-bit segment pattern back to its 4-bit code.
// Ports: segments[6:0] in; code[3:0], pattern_ok out (combinational).
module seg_pattern_decode
  import seven_segment_pkg::*;
(
  input  logic [6:0] segments,
  output logic [3:0] code,
  output logic       pattern_ok
);

  always_comb begin
    code       = 4'h0;
    pattern_ok = 1'b1;
    unique case (segments)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = BLANK_CODE;
      default:   pattern_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Reads a multiplexed two-digit seven-segment bus back into codes.
// Ports: clk, reset_n, segments_in[6:0], digit_in -> ten_count,
// unit_count, valid (pair strobe), pattern_error (bad pattern strobe).
module seven_segment_decoder
  import seven_segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] segments_in,
  input  logic       digit_in,
  output logic [3:0] ten_count,
  output logic [3:0] unit_count,
  output logic       valid,
  output logic       pattern_error
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [6:0] seg_q;
  logic       dig_q;
  logic [7:0] prev_q;
  logic [3:0] run_q, run_d;
  state_e     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [3:0] ten_q, ten_d;
  logic [3:0] unit_q, unit_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  logic [7:0] sample;
  logic       accept;
  logic [3:0] code;
  logic       pat_ok;

  assign sample = {dig_q, seg_q};

  seg_pattern_decode u_dec (
    .segments   (seg_q),
    .code       (code),
    .pattern_ok (pat_ok)
  );

  // A zero count means no change seen since reset: the cleared
  // input registers are not a real sample and are never accepted.
  always_comb begin
    run_d = run_q;
    if (sample != prev_q)
      run_d = 4'd1;
    else if (run_q != 4'd0 && run_q != 4'd15)
      run_d = run_q + 4'd1;
  end

  assign accept = (run_d == STABLE);

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (!pat_ok)
        state_d = WAIT_UNIT;
      else if (!dig_q)
        state_d = WAIT_TEN;
      else if (state_q == WAIT_TEN)
        state_d = WAIT_UNIT;
    end
  end

  always_comb begin
    pend_d  = pend_q;
    ten_d   = ten_q;
    unit_d  = unit_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      if (!pat_ok) begin
        err_d  = 1'b1;
        pend_d = 4'h0;
      end else if (!dig_q) begin
        pend_d = code;
      end else if (state_q == WAIT_TEN) begin
        ten_d   = code;
        unit_d  = pend_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q   <= '0;
      dig_q   <= 1'b0;
      prev_q  <= '0;
      run_q   <= '0;
      state_q <= WAIT_UNIT;
      pend_q  <= '0;
      ten_q   <= '0;
      unit_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      seg_q   <= segments_in;
      dig_q   <= digit_in;
      prev_q  <= sample;
      run_q   <= run_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      ten_q   <= ten_d;
      unit_q  <= unit_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ten_count     = ten_q;
  assign unit_count    = unit_q;
  assign valid         = valid_q;
  assign pattern_error = err_q;

endmodule
